// File: rtl/conv3x3_pe.sv
// conv3x3_pe: 3x3 convolution processing element with raster position
// tracking, a ten-entry coefficient register file and a four-stage
// multiply / reduce / bias / ReLU-shift-saturate pipeline.
//
// stage | contents
// S1    | nine tap*weight products
// S2    | three partial sums of three products
// S3    | total plus bias
// S4    | ReLU, arithmetic shift, saturate to 8 bits (out_pix)
module conv3x3_pe #(
  parameter int IMG_W = 30,
  parameter int IMG_H = 30,
  parameter int SHIFT = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_valid,
  input  logic [7:0] win1,
  input  logic [7:0] win2,
  input  logic [7:0] win3,
  input  logic [7:0] win4,
  input  logic [7:0] win5,
  input  logic [7:0] win6,
  input  logic [7:0] win7,
  input  logic [7:0] win8,
  input  logic [7:0] win9,
  input  logic       w_we,
  input  logic [3:0] w_addr,
  input  logic [7:0] w_data,
  output logic       out_valid,
  output logic [7:0] out_pix,
  output logic       frame_done,
  output logic       busy
);

  localparam int CW = (IMG_W > 4) ? $clog2(IMG_W) : 2;
  localparam int RW = (IMG_H > 4) ? $clog2(IMG_H) : 2;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_ACC0 = CW'(2);
  localparam logic [RW-1:0] ROW_ACC0 = RW'(2);

  logic [CW-1:0]      col_q, col_d;
  logic [RW-1:0]      row_q, row_d;
  logic signed [7:0]  coef_q [10];
  logic signed [7:0]  coef_d [10];
  logic [7:0]         tap [9];
  logic               accept, accept_last;

  logic               v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, ov_q, ov_d;
  logic               last1_q, last1_d, last2_q, last2_d, last3_q, last3_d;
  logic               fd_q, fd_d;
  logic signed [16:0] prod_q [9];
  logic signed [16:0] prod_d [9];
  logic signed [18:0] psum_q [3];
  logic signed [18:0] psum_d [3];
  logic signed [20:0] total_q, total_d;
  logic [20:0]        shifted;
  logic [7:0]         out_pix_q, out_pix_d;

  // gather the window taps, oldest first
  always_comb begin
    tap[0] = win1;
    tap[1] = win2;
    tap[2] = win3;
    tap[3] = win4;
    tap[4] = win5;
    tap[5] = win6;
    tap[6] = win7;
    tap[7] = win8;
    tap[8] = win9;
  end

  // raster position: advances only on pix_valid, wraps at frame end
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (pix_valid) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) row_d = '0;
        else                   row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // a window is complete once two full rows and two columns are behind it
  always_comb begin
    accept      = pix_valid && (row_q >= ROW_ACC0) && (col_q >= COL_ACC0);
    accept_last = accept && (row_q == ROW_LAST) && (col_q == COL_LAST);
  end

  // busy covers both a partially received frame and a non-empty pipeline
  assign busy = (col_q != '0) || (row_q != '0) || v1_q || v2_q || v3_q || ov_q;

  // coefficient register file; index 9 is the bias, 10..15 decode to nothing
  always_comb begin
    coef_d = coef_q;
    if (w_we && !busy) begin
      for (int k = 0; k < 10; k++) begin
        if (w_addr == 4'(k)) coef_d[k] = w_data;
      end
    end
  end

  // valid and end-of-frame markers travel alongside the data
  always_comb begin
    v1_d    = accept;
    last1_d = accept_last;
    v2_d    = v1_q;
    last2_d = last1_q;
    v3_d    = v2_q;
    last3_d = last2_q;
    ov_d    = v3_q;
    fd_d    = v3_q && last3_q;
  end

  // S1: unsigned taps times signed weights
  always_comb begin
    prod_d = prod_q;
    if (accept) begin
      for (int k = 0; k < 9; k++) begin
        prod_d[k] = $signed({9'b0, tap[k]}) * $signed({{9{coef_q[k][7]}}, coef_q[k]});
      end
    end
  end

  // S2: reduce nine products to three row sums
  always_comb begin
    psum_d = psum_q;
    if (v1_q) begin
      for (int j = 0; j < 3; j++) begin
        psum_d[j] = 19'(prod_q[3*j]) + 19'(prod_q[3*j+1]) + 19'(prod_q[3*j+2]);
      end
    end
  end

  // S3: final sum plus bias; bias cannot change while anything is in flight
  always_comb begin
    total_d = total_q;
    if (v2_q) begin
      total_d = 21'(psum_q[0]) + 21'(psum_q[1]) + 21'(psum_q[2]) + 21'(coef_q[9]);
    end
  end

  // S4: ReLU, scale down, clamp to 8 bits; hold the last result otherwise
  always_comb begin
    out_pix_d = out_pix_q;
    shifted   = '0;
    if (v3_q) begin
      if (total_q[20]) begin
        out_pix_d = 8'd0;
      end else begin
        shifted   = total_q >>> SHIFT;
        out_pix_d = (shifted > 21'd255) ? 8'hFF : shifted[7:0];
      end
    end
  end

  // all state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q     <= '0;
      row_q     <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      ov_q      <= 1'b0;
      last1_q   <= 1'b0;
      last2_q   <= 1'b0;
      last3_q   <= 1'b0;
      fd_q      <= 1'b0;
      total_q   <= '0;
      out_pix_q <= '0;
      for (int k = 0; k < 10; k++) coef_q[k] <= '0;
      for (int k = 0; k < 9; k++)  prod_q[k] <= '0;
      for (int j = 0; j < 3; j++)  psum_q[j] <= '0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      v3_q      <= v3_d;
      ov_q      <= ov_d;
      last1_q   <= last1_d;
      last2_q   <= last2_d;
      last3_q   <= last3_d;
      fd_q      <= fd_d;
      total_q   <= total_d;
      out_pix_q <= out_pix_d;
      coef_q    <= coef_d;
      prod_q    <= prod_d;
      psum_q    <= psum_d;
    end
  end

  assign out_valid  = ov_q;
  assign out_pix    = out_pix_q;
  assign frame_done = fd_q;

endmodule

// File: doc/conv3x3_pe.md
CONV3X3_PE -- requirements
Module: conv3x3_pe

Interface
REQ-001 Parameters SHALL be: IMG_W, default 30, input row width in pixels; IMG_H, default 30, input rows per frame; SHIFT, default 7, right-shift applied to the accumulated sum before output.
REQ-002 Ports SHALL be (name  direction  width  meaning):
  clk  input  1  single clock; all state updates on the rising edge.
  rst_n  input  1  asynchronous, active-low reset.
  pix_valid  input  1  win1..win9 hold a new 3x3 window this cycle; the newest pixel sits at win9.
  win1..win9  input  8 each  unsigned window taps; win1 = top-left (oldest), win9 = bottom-right (newest).
  w_we  input  1  coefficient write strobe.
  w_addr  input  4  coefficient index: 0..8 = weights w0..w8, 9 = bias, 10..15 = no effect.
  w_data  input  8  signed two's-complement coefficient value.
  out_valid  output  1  out_pix is valid this cycle.
  out_pix  output  8  unsigned result: ReLU, shift and saturate applied.
  frame_done  output  1  one-cycle pulse coincident with the last out_valid of a frame.
  busy  output  1  a frame or the pipeline is in progress.

Function
REQ-003 Coefficients SHALL be held in ten 8-bit signed registers, w0..w8 and bias.
REQ-004 Window product SHALL be sum(k=0..8) wk*win(k+1), with the taps zero-extended and the weights sign-extended, plus bias sign-extended; the accumulator SHALL be 21-bit signed and SHALL never overflow (max magnitude 293888).
REQ-005 A write with w_we=1 and busy=0 SHALL update the addressed register at the clock edge; a write with busy=1 SHALL be ignored.
REQ-006 Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) SHALL advance only on pix_valid=1; col wraps to 0 after IMG_W-1 and increments row; after pixel (IMG_H-1, IMG_W-1) both SHALL return to 0.
REQ-007 A window SHALL be accepted only when pix_valid=1, row>=2 and col>=2 (pre-increment values). All other pix_valid cycles SHALL only advance the counters.
REQ-008 Each frame SHALL yield exactly (IMG_W-2)*(IMG_H-2) accepted windows, 784 at the defaults, in raster order.
REQ-009 Pipeline SHALL be 4 registered stages, one valid bit per stage:
  - S1: nine products.
  - S2: three partial sums of three.
  - S3: total plus bias.
  - S4: ReLU, shift, saturate.
REQ-010 out_valid SHALL assert exactly 4 cycles after the clock edge at which the window was accepted; the pipeline SHALL accept one window per cycle with no stalls.
REQ-011 S4: if sum<0, out_pix=0; otherwise t = sum >>> SHIFT; out_pix = 255 if t>255, else t[7:0].
REQ-012 When out_valid=0, out_pix SHALL hold its last value.
REQ-013 frame_done SHALL pulse together with the out_valid of the window accepted at (row,col)=(IMG_H-1, IMG_W-1).
REQ-014 busy SHALL be 1 whenever (row,col) is not (0,0) or any pipeline valid bit is 1; it SHALL be 0 otherwise.
REQ-015 Gaps in pix_valid SHALL pause the counters without losing pipeline contents; the next frame MAY start in the cycle after the last pixel of the previous frame.
REQ-016 Coefficients used by a window SHALL be the register values at its acceptance edge; because of REQ-005, these are constant through a frame.

Reset
REQ-017 With rst_n=0, the following SHALL clear asynchronously: out_valid, out_pix, frame_done, busy, col, row, all pipeline valid bits and data registers, w0..w8 and bias (all 0).
REQ-018 Reset asserted mid-frame SHALL discard in-flight windows; no out_valid or frame_done SHALL occur until new windows are accepted after release.
REQ-019 In the first cycle after release, pixel (0,0) SHALL be accepted if pix_valid=1.

Verification
REQ-020 All weights 1, bias 0, SHIFT=0, all-ones 30x30 frame with continuous pix_valid -> 784 outputs all equal to 9, the first 4 cycles after window (2,2) is accepted, and a single frame_done on the 784th output.
REQ-021 w8=1, others 0, bias 0, SHIFT=0, pixel = column index -> each output row reads 2,3,...,29; out_valid low during cols 0-1 and rows 0-1.
REQ-022 All weights 127, pixels 255, SHIFT=7 -> out_pix=255 (saturation); all weights -1, pixels 10, bias 0 -> out_pix=0 (ReLU).
REQ-023 Write w0=5 while busy=1 mid-frame -> w0 unchanged and outputs unaffected; the same write after the frame is accepted.
REQ-024 Assert rst_n=0 at pixel 400 of a frame, release, stream a full frame -> no outputs from the aborted frame, exactly 784 outputs afterwards, and coefficients read 0 (all outputs 0 until reloaded).
REQ-025 Random pix_valid gaps (about 30% idle) over two back-to-back frames -> output values and count match the gap-free run, with one frame_done per frame.
